// File: rtl/prio_tag_merge.sv
// Purpose: strict-priority merge of hi/lo payload channels into one tagged stream (bit DW-1 = 1 for hi), bounded hi bursts.
// Latency: 1 cycle, single registered output slot; backpressure: input readies drop whenever the slot is held (vld_o && !rdy_i).
// Optional: PRIO_TAG_MERGE_STATS_EN adds saturating per-tag transfer counters hi_cnt_o / lo_cnt_o.
module prio_tag_merge #(
    parameter int DW           = 33,
    parameter int MAX_HI_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-2:0] hi_data_i,
    input  logic          hi_vld_i,
    output logic          hi_rdy_o,
    input  logic [DW-2:0] lo_data_i,
    input  logic          lo_vld_i,
    output logic          lo_rdy_o,
    output logic [DW-1:0] data_out,
    output logic          vld_o,
    input  logic          rdy_i
`ifdef PRIO_TAG_MERGE_STATS_EN
    ,
    output logic [15:0]   hi_cnt_o,
    output logic [15:0]   lo_cnt_o
`endif
);

    localparam int CW = (MAX_HI_BURST > 0) ? $clog2(MAX_HI_BURST + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HI_BURST);

    typedef struct packed {
        logic          tag;
        logic [DW-2:0] payload;
    } word_t;

    word_t         out_word;
    logic [CW-1:0] cnt;
    logic          slot_free;
    logic          force_lo;
    logic          hi_wins;
    logic          grant_hi;
    logic          grant_lo;

    assign slot_free = !vld_o || rdy_i;

    // Once low has waited out a full high burst, high is locked out for exactly one low grant.
    assign force_lo  = (MAX_HI_BURST != 0) && lo_vld_i && (cnt == CNT_MAX);
    assign hi_wins   = hi_vld_i && !force_lo;

    assign hi_rdy_o  = !rst && slot_free && !force_lo;
    assign lo_rdy_o  = !rst && slot_free && !hi_wins;
    assign grant_hi  = hi_rdy_o && hi_vld_i;
    assign grant_lo  = lo_rdy_o && lo_vld_i;

    assign data_out  = out_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_word <= '0;
            vld_o    <= 1'b0;
        end else if (grant_hi) begin
            out_word <= '{tag: 1'b1, payload: hi_data_i};
            vld_o    <= 1'b1;
        end else if (grant_lo) begin
            out_word <= '{tag: 1'b0, payload: lo_data_i};
            vld_o    <= 1'b1;
        end else if (rdy_i) begin
            vld_o    <= 1'b0;
        end
    end

    // Counts high grants taken while low is waiting; frozen while the slot is busy.
    always_ff @(posedge clk) begin
        if (rst || MAX_HI_BURST == 0) begin
            cnt <= '0;
        end else if (slot_free) begin
            if (grant_lo || !lo_vld_i) begin
                cnt <= '0;
            end else if (grant_hi && cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef PRIO_TAG_MERGE_STATS_EN
    logic xfer;
    assign xfer = vld_o && rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_o <= '0;
            lo_cnt_o <= '0;
        end else if (xfer) begin
            if (out_word.tag && hi_cnt_o != 16'hFFFF) begin
                hi_cnt_o <= hi_cnt_o + 16'd1;
            end
            if (!out_word.tag && lo_cnt_o != 16'hFFFF) begin
                lo_cnt_o <= lo_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prio_tag_merge.sv
// Directed bench for prio_tag_merge (DW=33, MAX_HI_BURST=4) with hand-computed expectations.
module tb_prio_tag_merge;

    logic        clk;
    logic        rst;
    logic [31:0] hi_data_i;
    logic        hi_vld_i;
    logic        hi_rdy_o;
    logic [31:0] lo_data_i;
    logic        lo_vld_i;
    logic        lo_rdy_o;
    logic [32:0] data_out;
    logic        vld_o;
    logic        rdy_i;
`ifdef PRIO_TAG_MERGE_STATS_EN
    logic [15:0] hi_cnt_o;
    logic [15:0] lo_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    prio_tag_merge #(.DW(33), .MAX_HI_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .hi_data_i (hi_data_i),
        .hi_vld_i  (hi_vld_i),
        .hi_rdy_o  (hi_rdy_o),
        .lo_data_i (lo_data_i),
        .lo_vld_i  (lo_vld_i),
        .lo_rdy_o  (lo_rdy_o),
        .data_out  (data_out),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i)
`ifdef PRIO_TAG_MERGE_STATS_EN
        ,
        .hi_cnt_o  (hi_cnt_o),
        .lo_cnt_o  (lo_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are read a further unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hi_vld_i = 1'b1; hi_data_i = 32'hAAAA_5555;
        lo_vld_i = 1'b0; lo_data_i = '0; rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld[%0d]: got %b want 0", i, vld_o); end
            checks++; if (data_out !== 33'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h want 0", i, data_out); end
            checks++; if (hi_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_hi_rdy[%0d]: got %b want 0", i, hi_rdy_o); end
            checks++; if (lo_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_lo_rdy[%0d]: got %b want 0", i, lo_rdy_o); end
`ifdef PRIO_TAG_MERGE_STATS_EN
            checks++; if (hi_cnt_o !== 16'd0 || lo_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stats[%0d]: got %0d/%0d want 0/0", i, hi_cnt_o, lo_cnt_o); end
`endif
        end
        rst = 1'b0; #1;
        checks++; if (hi_rdy_o !== 1'b1) begin errors++; $display("FAIL release_hi_rdy: got %b want 1", hi_rdy_o); end
        tick(); hi_vld_i = 1'b0; #1;
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL first_word_vld: got %b want 1", vld_o); end
        checks++; if (data_out !== 33'h1_AAAA_5555) begin errors++; $display("FAIL first_word_data: got %h want 1aaaa5555", data_out); end
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL first_word_drain: got %b want 0", vld_o); end
    endtask

    task automatic test_single_high();
        hi_data_i = 32'hDEAD_BEEF; hi_vld_i = 1'b1;
        tick(); hi_vld_i = 1'b0; #1;
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL single_hi_vld: got %b want 1", vld_o); end
        checks++; if (data_out !== 33'h1_DEAD_BEEF) begin errors++; $display("FAIL single_hi_data: got %h want 1deadbeef", data_out); end
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL single_hi_drain: got %b want 0", vld_o); end
    endtask

    task automatic test_single_low();
        lo_data_i = 32'h1234_5678; lo_vld_i = 1'b1; #1;
        checks++; if (lo_rdy_o !== 1'b1) begin errors++; $display("FAIL single_lo_rdy: got %b want 1", lo_rdy_o); end
        tick(); lo_vld_i = 1'b0; #1;
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL single_lo_vld: got %b want 1", vld_o); end
        checks++; if (data_out !== 33'h0_1234_5678) begin errors++; $display("FAIL single_lo_data: got %h want 012345678", data_out); end
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL single_lo_drain: got %b want 0", vld_o); end
    endtask

    // Both channels held valid; expected tag pattern drives per-channel payload sequencing.
    task automatic run_burst(input string name, input logic [31:0] hi_base, input logic [31:0] lo_base, input int n);
        logic exp_tag [10];
        int   hi_idx = 0;
        int   lo_idx = 0;
        logic [32:0] exp_word;
        exp_tag = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        hi_vld_i = 1'b1; lo_vld_i = 1'b1; rdy_i = 1'b1;
        hi_data_i = hi_base; lo_data_i = lo_base;
        for (int k = 0; k < n; k++) begin
            #1;
            checks++; if (lo_rdy_o !== !exp_tag[k]) begin errors++; $display("FAIL %s_lo_rdy[%0d]: got %b want %b", name, k, lo_rdy_o, !exp_tag[k]); end
            exp_word = exp_tag[k] ? {1'b1, hi_base + 32'(hi_idx)} : {1'b0, lo_base + 32'(lo_idx)};
            tick(); #1;
            checks++; if (vld_o !== 1'b1 || data_out !== exp_word) begin errors++; $display("FAIL %s_word[%0d]: got vld=%b %h want vld=1 %h", name, k, vld_o, data_out, exp_word); end
            if (exp_tag[k]) hi_idx++; else lo_idx++;
            hi_data_i = hi_base + 32'(hi_idx);
            lo_data_i = lo_base + 32'(lo_idx);
        end
        hi_vld_i = 1'b0; lo_vld_i = 1'b0;
    endtask

    task automatic test_starvation();
        run_burst("starve", 32'h1000_0000, 32'h2000_0000, 10);
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL starve_drain: got %b want 0", vld_o); end
    endtask

    task automatic test_backpressure();
        hi_data_i = 32'hCAFE_0001; hi_vld_i = 1'b1; rdy_i = 1'b1;
        tick();
        rdy_i = 1'b0; hi_data_i = 32'hCAFE_0002; lo_vld_i = 1'b1; lo_data_i = 32'hBEEF_0001; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (hi_rdy_o !== 1'b0 || lo_rdy_o !== 1'b0) begin errors++; $display("FAIL bp_rdy[%0d]: got hi=%b lo=%b want 0/0", i, hi_rdy_o, lo_rdy_o); end
            tick(); #1;
            checks++; if (vld_o !== 1'b1 || data_out !== 33'h1_CAFE_0001) begin errors++; $display("FAIL bp_hold[%0d]: got vld=%b %h want vld=1 1cafe0001", i, vld_o, data_out); end
        end
        rdy_i = 1'b1; #1;
        checks++; if (hi_rdy_o !== 1'b1 || lo_rdy_o !== 1'b0) begin errors++; $display("FAIL bp_release_rdy: got hi=%b lo=%b want 1/0", hi_rdy_o, lo_rdy_o); end
        tick(); hi_vld_i = 1'b0; #1;
        checks++; if (data_out !== 33'h1_CAFE_0002) begin errors++; $display("FAIL bp_next_hi: got %h want 1cafe0002", data_out); end
        tick(); lo_vld_i = 1'b0; #1;
        checks++; if (data_out !== 33'h0_BEEF_0001) begin errors++; $display("FAIL bp_next_lo: got %h want 0beef0001", data_out); end
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", vld_o); end
    endtask

    task automatic test_reset_mid_burst();
        hi_vld_i = 1'b1; lo_vld_i = 1'b1; rdy_i = 1'b1;
        hi_data_i = 32'h3000_0000; lo_data_i = 32'h4000_0000;
        tick(); hi_data_i = 32'h3000_0001;
        tick(); hi_data_i = 32'h3000_0002; #1;
        checks++; if (data_out !== 33'h1_3000_0001) begin errors++; $display("FAIL mid_pre_word: got %h want 130000001", data_out); end
        rst = 1'b1; #1;
        checks++; if (hi_rdy_o !== 1'b0 || lo_rdy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy: got hi=%b lo=%b want 0/0", hi_rdy_o, lo_rdy_o); end
        tick(); rst = 1'b0; #1;
        checks++; if (vld_o !== 1'b0 || data_out !== 33'h0) begin errors++; $display("FAIL mid_rst_drop: got vld=%b %h want vld=0 0", vld_o, data_out); end
`ifdef PRIO_TAG_MERGE_STATS_EN
        checks++; if (hi_cnt_o !== 16'd0 || lo_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_rst_stats: got %0d/%0d want 0/0", hi_cnt_o, lo_cnt_o); end
`endif
        run_burst("mid", 32'h3000_0002, 32'h4000_0000, 5);
        tick(); #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL mid_drain: got %b want 0", vld_o); end
`ifdef PRIO_TAG_MERGE_STATS_EN
        checks++; if (hi_cnt_o !== 16'd4 || lo_cnt_o !== 16'd1) begin errors++; $display("FAIL mid_stats: got %0d/%0d want 4/1", hi_cnt_o, lo_cnt_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_high();
        test_single_low();
        test_starvation();
        test_backpressure();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
